// File: rtl/seq_digit_display.sv
// Sequential decimal display: latches a value, converts it to BCD one bit per cycle
// (double dabble), then shows the digits MSD-first on one seven-segment digit.
module seq_digit_display #(
  parameter int WIDTH         = 8,
  parameter int NUM_DIGITS    = 3,
  parameter int DIGIT_CYCLES  = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int BLANK_LEADING = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [WIDTH-1:0] value,
  output logic [6:0]       seg,
  output logic             digit_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX = pow10(NUM_DIGITS) - 64'd1;
  localparam int BW   = 4 * NUM_DIGITS;
  localparam int PW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW   = $clog2(WIDTH + 1);
  localparam int CMAX = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [3:0] CODE_OFF = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_SHOW, S_GAP, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] val_sh, val_sh_nx;
  logic [BW-1:0]    bcd, bcd_nx, adj;
  logic [SW-1:0]    scnt, scnt_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [PW-1:0]    ptr, ptr_nx, lead;
  logic [3:0]       code, code_nx;
  logic             ovf_nx;
  logic             unused_adj_msb;

  // Saturation keeps the value <= MAX, so the top BCD bit never carries out.
  assign unused_adj_msb = adj[BW-1];

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

  // Highest nonzero digit; all-zero falls back to digit 0 so "0" is still shown.
  always_comb begin
    lead = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) lead = PW'(i);
  end

  always_comb begin
    state_nx  = state;
    val_sh_nx = val_sh;
    bcd_nx    = bcd;
    scnt_nx   = scnt;
    cnt_nx    = cnt;
    ptr_nx    = ptr;
    ovf_nx    = overflow;
    case (state)
      S_IDLE: if (trigger) begin
        ovf_nx    = 64'(value) > MAX;
        val_sh_nx = ovf_nx ? MAX[WIDTH-1:0] : value;
        bcd_nx    = '0;
        scnt_nx   = '0;
        state_nx  = S_CONVERT;
      end
      S_CONVERT: begin
        if (scnt == SW'(WIDTH)) begin
          ptr_nx   = (BLANK_LEADING != 0) ? lead : PW'(NUM_DIGITS - 1);
          cnt_nx   = '0;
          state_nx = S_SHOW;
        end else begin
          bcd_nx    = {adj[BW-2:0], val_sh[WIDTH-1]};
          val_sh_nx = val_sh << 1;
          scnt_nx   = scnt + SW'(1);
        end
      end
      S_SHOW: begin
        if (cnt == CW'(DIGIT_CYCLES - 1)) begin
          cnt_nx = '0;
          if (GAP_CYCLES > 0)    state_nx = S_GAP;
          else if (ptr == '0)    state_nx = S_DONE;
          else                   ptr_nx   = ptr - PW'(1);
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (GAP_CYCLES == 0 || cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_nx = '0;
          if (ptr == '0) state_nx = S_DONE;
          else begin
            ptr_nx   = ptr - PW'(1);
            state_nx = S_SHOW;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    code_nx = (state_nx == S_SHOW) ? bcd_nx[{ptr_nx, 2'b00} +: 4] : CODE_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      val_sh      <= '0;
      bcd         <= '0;
      scnt        <= '0;
      cnt         <= '0;
      ptr         <= '0;
      code        <= CODE_OFF;
      digit_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nx;
      val_sh      <= val_sh_nx;
      bcd         <= bcd_nx;
      scnt        <= scnt_nx;
      cnt         <= cnt_nx;
      ptr         <= ptr_nx;
      code        <= code_nx;
      digit_valid <= (state_nx == S_SHOW);
      busy        <= (state_nx != S_IDLE);
      done        <= (state_nx == S_DONE);
      overflow    <= ovf_nx;
    end
  end

  // Segment order {g,f,e,d,c,b,a}, active high; any code above 9 blanks the digit.
  always_comb begin
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_seq_digit_display.sv
// Bench for seq_digit_display: three instances (defaults, no leading-blank, WIDTH=10)
// checked cycle by cycle against a digit-list model of the display sequence.
module tb_seq_digit_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      trig;
  logic [7:0]      v0, v1;
  logic [9:0]      v2;
  logic [2:0][6:0] seg;
  logic [2:0]      dv, bz, dn, ov;

  int checks   = 0;
  int failures = 0;

  seq_digit_display dut0 (
    .clk(clk), .rst(rst), .trigger(trig[0]), .value(v0), .seg(seg[0]),
    .digit_valid(dv[0]), .busy(bz[0]), .done(dn[0]), .overflow(ov[0]));

  seq_digit_display #(.BLANK_LEADING(0)) dut1 (
    .clk(clk), .rst(rst), .trigger(trig[1]), .value(v1), .seg(seg[1]),
    .digit_valid(dv[1]), .busy(bz[1]), .done(dn[1]), .overflow(ov[1]));

  seq_digit_display #(.WIDTH(10)) dut2 (
    .clk(clk), .rst(rst), .trigger(trig[2]), .value(v2), .seg(seg[2]),
    .digit_valid(dv[2]), .busy(bz[2]), .done(dn[2]), .overflow(ov[2]));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] segpat(input int c);
    case (c)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [10:0] actual(input int which);
    return {seg[which], dv[which], bz[which], dn[which], ov[which]};
  endfunction

  task automatic drive(input int which, input logic t, input int v);
    case (which)
      0: begin trig[0] = t; v0 = v[7:0]; end
      1: begin trig[1] = t; v1 = v[7:0]; end
      default: begin trig[2] = t; v2 = v[9:0]; end
    endcase
  endtask

  // mode 0: single trigger; 1: random trigger/value noise while busy; 2: trigger held high
  task automatic run_check(input int which, input int v, input int mode);
    int w, sat, first, d, cur;
    int dig[3];
    int codes[$];
    bit ovf;
    logic [10:0] exp, act;
    w   = (which == 2) ? 10 : 8;
    ovf = (v > 999);
    sat = ovf ? 999 : v;
    d = 1;
    for (int i = 0; i < 3; i++) begin
      dig[i] = (sat / d) % 10;
      d = d * 10;
    end
    first = 2;
    if (which != 1) begin
      first = 0;
      for (int i = 0; i < 3; i++) if (dig[i] != 0) first = i;
    end
    // codes: 0-9 digit shown, 10 blank & busy, 11 done cycle, 12 idle
    codes = {};
    for (int i = 0; i <= w; i++) codes.push_back(10);
    for (int i = first; i >= 0; i--) begin
      repeat (4) codes.push_back(dig[i]);
      repeat (2) codes.push_back(10);
    end
    codes.push_back(11);
    codes.push_back(12);

    @(negedge clk);
    drive(which, 1'b1, v);
    @(posedge clk);
    #1;
    for (int i = 0; i < codes.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (mode == 1)      drive(which, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
        else if (mode == 2) drive(which, 1'b1, v);
        else                drive(which, 1'b0, v);
        @(posedge clk);
        #1;
      end
      cur = codes[i];
      exp = {segpat(cur), cur < 10, cur != 12, cur == 11, ovf};
      act = actual(which);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL seq inst=%0d v=%0d cyc=%0d got=%h exp=%h", which, v, i, act, exp);
      end
    end
    @(negedge clk);
    if (mode != 2) drive(which, 1'b0, v);
    @(posedge clk);
    #1;
    act = actual(which);
    exp = (mode == 2) ? {7'h00, 1'b0, 1'b1, 1'b0, ovf} : {7'h00, 1'b0, 1'b0, 1'b0, ovf};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL post inst=%0d v=%0d mode=%0d got=%h exp=%h", which, v, mode, act, exp);
    end
    if (mode == 2) begin
      @(negedge clk);
      drive(which, 1'b0, v);
      repeat (codes.size() + 2) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b0;
    trig = '0;
    v0 = '0; v1 = '0; v2 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (actual(i) !== 11'h0) begin
        failures++;
        $display("FAIL reset inst=%0d got=%h exp=%h", i, actual(i), 11'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (actual(0) !== 11'h0) begin
      failures++;
      $display("FAIL idle_after_reset got=%h exp=%h", actual(0), 11'h0);
    end
  endtask

  task automatic test_basic;
    run_check(0, 123, 0);
  endtask

  task automatic test_leading;
    run_check(0, 7, 0);
    run_check(1, 7, 0);
    run_check(0, 40, 0);
    run_check(1, 205, 0);
  endtask

  task automatic test_zero;
    run_check(0, 0, 0);
    run_check(1, 0, 0);
  endtask

  task automatic test_overflow;
    run_check(2, 1023, 0);
    run_check(2, 5, 0);
    run_check(2, 999, 0);
    run_check(2, 1000, 0);
  endtask

  task automatic test_back_to_back;
    run_check(0, 200, 1);
    run_check(2, 618, 1);
    run_check(0, 90, 2);
  endtask

  task automatic test_random;
    for (int n = 0; n < 5; n++) begin
      run_check(0, int'($urandom_range(0, 255)), 0);
      run_check(1, int'($urandom_range(0, 255)), 0);
      run_check(2, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    drive(2, 1'b1, 1023);
    @(posedge clk);
    @(negedge clk);
    drive(2, 1'b0, 0);
    // WIDTH=10: first digit after edges k+11..k+14, second after k+17..k+20
    repeat (17) @(posedge clk);
    #2;
    checks++;
    if (actual(2) !== {segpat(9), 1'b1, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL abort_pre got=%h exp=%h", actual(2), {segpat(9), 4'b1101});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (actual(2) !== 11'h0) begin
      failures++;
      $display("FAIL abort_async got=%h exp=%h", actual(2), 11'h0);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (actual(2) !== 11'h0) begin
        failures++;
        $display("FAIL abort_hold got=%h exp=%h", actual(2), 11'h0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    run_check(2, int'($urandom_range(0, 1023)), 0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_leading;
    test_zero;
    test_overflow;
    test_back_to_back;
    test_random;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_digit_display.md
Name: seq_digit_display

Overview:
Parametrised successor to the fixed 3-digit sequential display controller. On a trigger it latches a WIDTH-bit unsigned value and converts it to BCD with a sequential double-dabble engine, one bit per cycle. It then shows the decimal digits one after another, most significant first, on a single seven-segment digit. Each digit is held for a programmable dwell time and followed by an optional blank gap. Leading zeros are optionally skipped, and out-of-range values saturate. Sits between game logic and the seg pins.

Parameters:
WIDTH, 8, bit width of value
NUM_DIGITS, 3, number of decimal digits (MAX = 10^NUM_DIGITS - 1)
DIGIT_CYCLES, 4, clock cycles each digit is shown (>=1)
GAP_CYCLES, 2, blank cycles after each digit (0 = no gap)
BLANK_LEADING, 1, 1 = skip leading zero digits; 0 = show all NUM_DIGITS

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
trigger  input  1  start request, sampled only in IDLE
value  input  WIDTH  unsigned number to display, sampled with trigger
seg  output  7  segment pattern, produced by the team seven-segment decoder; digit code 10 = all segments off
digit_valid  output  1  high while seg shows a digit (SHOW state)
busy  output  1  high from the trigger-accept edge until done deasserts
done  output  1  one-cycle pulse when the sequence completes
overflow  output  1  registered; set at trigger accept if value > MAX, held until next accept

Behaviour:
- Reset (rst low, asynchronous) forces the following, whatever the current state:
  - state = IDLE
  - seg = off-pattern (code 10); digit_valid = 0, busy = 0, done = 0, overflow = 0
  - all counters and the BCD register = 0
- States: IDLE, CONVERT, SHOW, GAP, DONE.
- IDLE:
  - seg off.
  - At an edge with trigger = 1, latch min(value, MAX) and set overflow = (value > MAX).
  - Clear the BCD register and set the shift counter to 0.
  - Go to CONVERT; busy = 1 from this edge.
- CONVERT:
  - Each cycle performs one double-dabble step: add 3 to every BCD nibble >= 5, then shift the BCD register left, shifting in the next value bit (MSB first).
  - After exactly WIDTH steps, go to SHOW; seg is off throughout CONVERT.
  - Latency: trigger-accept edge k, first digit on seg after edge k+WIDTH+1.
  - The BCD register is 4*NUM_DIGITS bits. Saturation guarantees no BCD overflow.
- Digit pointer, loaded at the CONVERT->SHOW transition:
  - BLANK_LEADING = 1: points at the most significant nonzero digit; value 0 shows the single least significant digit "0".
  - BLANK_LEADING = 0: points at digit NUM_DIGITS-1.
- SHOW:
  - seg = decode(current nibble); digit_valid = 1.
  - Held DIGIT_CYCLES cycles, then go to GAP (GAP_CYCLES > 0) or straight to the next digit or DONE.
- GAP:
  - seg off; digit_valid = 0; held GAP_CYCLES cycles.
  - Then the pointer decrements: next SHOW, or DONE after digit 0.
- DONE:
  - Exactly one cycle: done = 1, busy = 1, seg off.
  - Next edge: IDLE, busy = 0.
- Trigger handling:
  - trigger while busy is ignored, not queued.
  - trigger held high continuously restarts on the first IDLE cycle after DONE.
- value changes after the accept edge have no effect.
- Sequence length after CONVERT = D * (DIGIT_CYCLES + GAP_CYCLES) cycles, where D = number of digits shown. DONE follows immediately.
- rst asserted mid-sequence aborts at once, with no done pulse.
- All outputs are registered, except seg, which decodes the registered nibble/blank selection combinationally.

Test Plan:
1. Defaults; value=123, trigger edge k -> seg off edges k..k+8; "1","2","3" each 4 cycles with 2 blank cycles after each; done=1 only in cycle after edge k+27; busy low next cycle.
2. value=7, BLANK_LEADING=1 -> only "7" shown (4 cycles + 2 gap); done after edge k+15. Rerun with BLANK_LEADING=0 -> "0","0","7".
3. value=0 -> single "0" shown; overflow=0.
4. WIDTH=10, value=1023 -> overflow=1; "9","9","9" shown; overflow stays 1 until next accepted trigger with value=5, which clears it.
5. Trigger pulsed every cycle during busy, value changing -> displayed digits match the originally latched value; exactly one done pulse per accepted trigger.
6. rst low during second SHOW digit -> all outputs at reset values immediately (asynchronous); no done pulse; a new trigger after release runs a full correct sequence.
